// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
// The master modport is the fetch unit's view; slave is the memory/decode/branch side.
interface instruction_fetch_unit_if;
    logic [29:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [29:0] out_pc;
    logic [29:0] out_pc_plus4;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, fetch queue of {pc, instr} and redirect/flush control.
// Define IFU_ALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
module instruction_fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h0,
    parameter int          DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_unit_if.master   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_FETCH, ST_STALL, ST_FAULT} state_t;
`else
    typedef enum logic [1:0] {ST_FETCH, ST_STALL} state_t;
`endif

    state_t             state_reg,    state_next;
    logic [29:0]        fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]   count_reg,    count_next;
    logic [PTR_W-1:0]   wr_ptr_reg,   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg,   rd_ptr_next;

    logic [29:0]        pc_q    [DEPTH];
    logic [31:0]        instr_q [DEPTH];

    logic               head_valid;
    logic               push;
    logic               pop;

    assign head_valid = (count_reg != '0);

    // STALL is exactly "queue full"; a pop in the same cycle still frees a slot for the push.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        push          = 1'b0;
        pop           = 1'b0;

        case (state_reg)
            ST_FETCH, ST_STALL: begin
                if (bus.redirect_valid) begin
                    fetch_pc_next = bus.redirect_pc;
                    count_next    = '0;
                    wr_ptr_next   = '0;
                    rd_ptr_next   = '0;
                    state_next    = ST_FETCH;
`ifdef IFU_ALIGN_CHECK_EN
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        state_next = ST_FAULT;
                    end
`endif
                end else begin
                    pop  = head_valid && bus.out_ready;
                    push = (state_reg == ST_FETCH) || pop;
                    if (push) begin
                        fetch_pc_next = fetch_pc_reg + 30'd4;
                        wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                    end
                    case ({push, pop})
                        2'b10:   count_next = count_reg + CNT_W'(1);
                        2'b01:   count_next = count_reg - CNT_W'(1);
                        default: count_next = count_reg;
                    endcase
                    state_next = (count_next == CNT_W'(DEPTH)) ? ST_STALL : ST_FETCH;
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
`endif
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_FETCH;
            fetch_pc_reg <= RESET_PC;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Payload storage needs no reset: every output is masked by head_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_reg]    <= fetch_pc_reg;
            instr_q[wr_ptr_reg] <= bus.imem_instr;
        end
    end

    assign bus.imem_addr    = fetch_pc_reg;
    assign bus.out_valid    = head_valid;
    assign bus.out_instr    = head_valid ? instr_q[rd_ptr_reg] : 32'h0;
    assign bus.out_pc       = head_valid ? pc_q[rd_ptr_reg] : 30'h0;
    assign bus.out_pc_plus4 = head_valid ? (pc_q[rd_ptr_reg] + 30'd4) : 30'h0;

`ifdef IFU_ALIGN_CHECK_EN
    assign bus.fault = (state_reg == ST_FAULT);
`else
    assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit: dut0 (RESET_PC=0) carries the main scenarios,
// dut1 (RESET_PC=3FFFFFF8) covers PC wrap-around. Honours IFU_ALIGN_CHECK_EN.
module tb_instruction_fetch_unit;

    typedef struct {
        logic [29:0] pc;
        logic [31:0] instr;
        logic [29:0] pc4;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rst1_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pops0    = 0;
    int   pops1    = 0;
    exp_t exp0[$];
    exp_t exp1[$];

    instruction_fetch_unit_if bus0();
    instruction_fetch_unit_if bus1();

    instruction_fetch_unit #(.RESET_PC(30'h0), .DEPTH(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    instruction_fetch_unit #(.RESET_PC(30'h3FFFFFF8), .DEPTH(2)) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte-addressed memory built from a small word table.
    function automatic logic [31:0] word_at(input logic [29:0] a);
        case (a)
            30'h00:  return 32'h00430820;
            30'h04:  return 32'h00A62022;
            30'h08:  return 32'h10E80001;
            30'h28:  return 32'h08000100;
            default: return {2'b10, a};
        endcase
    endfunction

    function automatic logic [31:0] mem_read(input logic [29:0] a);
        logic [31:0] w;
        logic [31:0] r;
        logic [29:0] b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            b = a + 30'(k);
            w = word_at({b[29:2], 2'b00});
            r = {r[23:0], w[8*(3-int'(b[1:0])) +: 8]};
        end
        return r;
    endfunction

    assign bus0.imem_instr = mem_read(bus0.imem_addr);
    assign bus1.imem_instr = mem_read(bus1.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [29:0] pc, input logic [31:0] instr, input logic [29:0] pc4);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pc4 = pc4;
        exp0.push_back(e);
    endtask

    task automatic push0_seq(input logic [29:0] start, input int n);
        logic [29:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 30'(4 * i);
            push0(p, mem_read(p), p + 30'd4);
        end
    endtask

    // Monitors: one compare set per accepted head; a pop in a redirect cycle is flushed, not delivered.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus0.out_valid && bus0.out_ready && !bus0.redirect_valid) begin
            pops0++;
            if (exp0.size() == 0) begin
                n_checks++;
                $display("FAIL dut0_unexpected: got pc %h, expected no output", bus0.out_pc);
            end else begin
                e = exp0.pop_front();
                chk("dut0_pc", {2'b0, bus0.out_pc}, {2'b0, e.pc});
                chk("dut0_instr", bus0.out_instr, e.instr);
                chk("dut0_pc_plus4", {2'b0, bus0.out_pc_plus4}, {2'b0, e.pc4});
                $display("dut0 pop pc=%h instr=%h", bus0.out_pc, bus0.out_instr);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst1_n && bus1.out_valid && bus1.out_ready && !bus1.redirect_valid) begin
            pops1++;
            if (exp1.size() == 0) begin
                n_checks++;
                $display("FAIL dut1_unexpected: got pc %h, expected no output", bus1.out_pc);
            end else begin
                e = exp1.pop_front();
                chk("dut1_pc", {2'b0, bus1.out_pc}, {2'b0, e.pc});
                chk("dut1_instr", bus1.out_instr, e.instr);
                chk("dut1_pc_plus4", {2'b0, bus1.out_pc_plus4}, {2'b0, e.pc4});
                $display("dut1 pop pc=%h instr=%h", bus1.out_pc, bus1.out_instr);
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: got timeout, expected $finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        bus0.out_ready      = 1'b0;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc    = 30'h0;
        bus1.out_ready      = 1'b1;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = 30'h0;
        #1;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, bus0.out_valid}, 32'h0);
        chk("rst_out_instr", bus0.out_instr, 32'h0);
        chk("rst_out_pc", {2'b0, bus0.out_pc}, 32'h0);
        chk("rst_out_pc_plus4", {2'b0, bus0.out_pc_plus4}, 32'h0);
        chk("rst_fault", {31'b0, bus0.fault}, 32'h0);
        chk("rst_imem_addr", {2'b0, bus0.imem_addr}, 32'h0);
        chk("rst_imem_addr_dut1", {2'b0, bus1.imem_addr}, 32'h3FFFFFF8);
        chk("rst_out_valid_dut1", {31'b0, bus1.out_valid}, 32'h0);

        // Release reset: dut0 stalls with out_ready=0, dut1 streams across the wrap.
        tick();
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        e1.pc = 30'h3FFFFFF8; e1.instr = 32'hBFFFFFF8; e1.pc4 = 30'h3FFFFFFC; exp1.push_back(e1);
        e1.pc = 30'h3FFFFFFC; e1.instr = 32'hBFFFFFFC; e1.pc4 = 30'h0;        exp1.push_back(e1);
        e1.pc = 30'h0;        e1.instr = 32'h00430820; e1.pc4 = 30'h4;        exp1.push_back(e1);
        push0(30'h0, 32'h00430820, 30'h4);
        push0(30'h4, 32'h00A62022, 30'h8);
        push0(30'h8, 32'h10E80001, 30'hC);
        push0_seq(30'hC, 13);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out_valid", {31'b0, bus0.out_valid}, 32'h1);
            chk("stall_out_pc", {2'b0, bus0.out_pc}, 32'h0);
            if (i >= 1) chk("stall_imem_addr", {2'b0, bus0.imem_addr}, 32'h8);
            if (i == 3) begin
                chk("dut1_drained", exp1.size(), 32'h0);
                chk("dut1_pops", pops1, 32'd3);
                rst1_n = 1'b0;
            end
        end

        // Release the stall: six back-to-back pops 0..0x14.
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("stream_pops", pops0, 32'd6);

        // Refill to full, then redirect while full with a discarded pop.
        bus0.out_ready = 1'b0;
        tick();
        chk("full_imem_addr", {2'b0, bus0.imem_addr}, 32'h20);
        chk("full_out_pc", {2'b0, bus0.out_pc}, 32'h18);
        tick();
        chk("full_imem_addr_stable", {2'b0, bus0.imem_addr}, 32'h20);
        chk("full_out_pc_stable", {2'b0, bus0.out_pc}, 32'h18);
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 30'h28;
        bus0.out_ready      = 1'b1;
        exp0.delete();
        push0(30'h28, 32'h08000100, 30'h2C);
        push0_seq(30'h2C, 8);
        tick();
        bus0.redirect_valid = 1'b0;
        chk("redir_n1_out_valid", {31'b0, bus0.out_valid}, 32'h0);
        chk("redir_n1_imem_addr", {2'b0, bus0.imem_addr}, 32'h28);
        tick();
        chk("redir_n2_out_valid", {31'b0, bus0.out_valid}, 32'h1);
        chk("redir_n2_out_pc", {2'b0, bus0.out_pc}, 32'h28);
        tick();
        tick();

        // Asynchronous reset pulse between edges mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, bus0.out_valid}, 32'h0);
        chk("arst_out_instr", bus0.out_instr, 32'h0);
        chk("arst_out_pc", {2'b0, bus0.out_pc}, 32'h0);
        chk("arst_out_pc_plus4", {2'b0, bus0.out_pc_plus4}, 32'h0);
        chk("arst_imem_addr", {2'b0, bus0.imem_addr}, 32'h0);
        exp0.delete();
        push0(30'h0, 32'h00430820, 30'h4);
        push0(30'h4, 32'h00A62022, 30'h8);
        push0(30'h8, 32'h10E80001, 30'hC);
        push0_seq(30'hC, 6);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_out_valid", {31'b0, bus0.out_valid}, 32'h1);
        end

        // Misaligned redirect to 0x2.
        tick();
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 30'h2;
        exp0.delete();
        push0(30'h2, 32'h082000A6, 30'h6);
        push0(30'h6, 32'h202210E8, 30'hA);
        tick();
        bus0.redirect_valid = 1'b0;
        chk("unal_n1_out_valid", {31'b0, bus0.out_valid}, 32'h0);
        chk("unal_n1_imem_addr", {2'b0, bus0.imem_addr}, 32'h2);
`ifdef IFU_ALIGN_CHECK_EN
        chk("unal_n1_fault", {31'b0, bus0.fault}, 32'h1);
        exp0.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            bus0.redirect_valid = (i == 1);
            bus0.redirect_pc    = 30'h28;
            chk("fault_sticky", {31'b0, bus0.fault}, 32'h1);
            chk("fault_out_valid", {31'b0, bus0.out_valid}, 32'h0);
            chk("fault_imem_addr", {2'b0, bus0.imem_addr}, 32'h2);
        end
        bus0.redirect_valid = 1'b0;
        bus0.out_ready      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("fault_cleared", {31'b0, bus0.fault}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
`else
        chk("unal_n1_fault", {31'b0, bus0.fault}, 32'h0);
        tick();
        chk("unal_n2_out_valid", {31'b0, bus0.out_valid}, 32'h1);
        chk("unal_n2_out_pc", {2'b0, bus0.out_pc}, 32'h2);
        tick();
        tick();
        bus0.out_ready = 1'b0;
        chk("unal_drained", exp0.size(), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unal_fault_low", {31'b0, bus0.fault}, 32'h0);
        end
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
